i2c_target_regfile: RTL and testbench

//   Parametrised I2C target (7-bit addressing) with an internal register file.
//   SCL/SDA are oversampled on the system clock; there is no logic in the SCL domain.

---
 rtl/i2c_target_regfile.sv | 249 ++++++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// I2C target (7-bit address) with an auto-incrementing 8-bit register file.
// SCL/SDA are oversampled on clk; an optional per-register even parity bit flags corrupted bus reads.
module i2c_target_regfile #(
  parameter int NUM_REGS    = 16,
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_EN   = 0,
  localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       slave_addr,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic [IDX_W-1:0] app_idx,
  output logic [7:0]       app_rdata,
  output logic             bus_wr_pulse,
  output logic [IDX_W-1:0] bus_wr_idx,
  output logic [7:0]       bus_wr_data,
  output logic             busy,
  input  logic             par_inject,
  output logic             parity_err
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_PTR  = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_RD   = 3'd4;
  localparam logic [2:0] ST_WAIT = 3'd5;

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
    if (32'(p) == 32'(NUM_REGS - 1)) begin
      return {IDX_W{1'b0}};
    end else begin
      return p + IDX_W'(1);
    end
  endfunction

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_q;
  logic                   r_sda_q;

  logic [2:0]             r_state;
  logic [3:0]             r_bit_cnt;
  logic                   r_ack;
  logic [7:0]             r_shift;
  logic [IDX_W-1:0]       r_ptr;
  logic                   r_busy;
  logic                   r_sda_oe;
  logic                   r_rw;
  logic                   r_mack;
  logic                   r_wr_pulse;
  logic [IDX_W-1:0]       r_wr_idx;
  logic [7:0]             r_wr_data;
  logic                   r_par_err;
  logic                   r_inj_pend;
  logic [7:0]             r_regs [NUM_REGS];
  logic                   r_par  [NUM_REGS];

  logic w_scl;
  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;
  logic w_ptr_ok;
  logic w_do_load;
  logic [7:0] w_rd_byte;
  logic w_rd_par_bad;

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_q;
  assign w_scl_fall = ~w_scl & r_scl_q;
  assign w_start    = r_scl_q & w_scl & r_sda_q & ~w_sda;
  assign w_stop     = r_scl_q & w_scl & ~r_sda_q & w_sda;
  assign w_ptr_ok   = (32'(r_shift) < 32'(NUM_REGS));
  assign w_rd_byte  = r_regs[r_ptr];
  assign w_rd_par_bad = (PARITY_EN != 0) && (even_par(w_rd_byte) != r_par[r_ptr]);

  // A read byte is fetched on the SCL fall closing our address ACK or a master ACK.
  assign w_do_load = ~w_start & ~w_stop & w_scl_fall & r_ack &
                     (((r_state == ST_ADDR) & r_rw) | ((r_state == ST_RD) & r_mack));

  // Pin synchronisers plus one delayed copy for edge and START/STOP detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= {SYNC_STAGES{1'b1}};
      r_sda_sync <= {SYNC_STAGES{1'b1}};
      r_scl_q    <= 1'b1;
      r_sda_q    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_q    <= w_scl;
      r_sda_q    <= w_sda;
    end
  end

  // Protocol FSM, register file and bus-side strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 4'd0;
      r_ack      <= 1'b0;
      r_shift    <= 8'd0;
      r_ptr      <= {IDX_W{1'b0}};
      r_busy     <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_rw       <= 1'b0;
      r_mack     <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_wr_idx   <= {IDX_W{1'b0}};
      r_wr_data  <= 8'd0;
      r_par_err  <= 1'b0;
      r_inj_pend <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= 8'd0;
        r_par[i]  <= 1'b0;
      end
    end else begin
      r_wr_pulse <= 1'b0;
      r_par_err  <= 1'b0;
      if (par_inject) begin
        r_inj_pend <= 1'b1;
      end
      if (w_start) begin
        r_state   <= ST_ADDR;
        r_bit_cnt <= 4'd0;
        r_ack     <= 1'b0;
        r_sda_oe  <= 1'b0;
      end else if (w_stop) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= 4'd0;
        r_ack     <= 1'b0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR, ST_PTR, ST_WR: begin
            if (w_scl_rise && !r_ack && (r_bit_cnt < 4'd8)) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && !r_ack && (r_bit_cnt == 4'd8)) begin
              case (r_state)
                ST_ADDR: begin
                  if (r_shift[7:1] == slave_addr) begin
                    r_ack    <= 1'b1;
                    r_sda_oe <= 1'b1;
                    r_busy   <= 1'b1;
                    r_rw     <= r_shift[0];
                  end else begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                  end
                end
                ST_PTR: begin
                  if (w_ptr_ok) begin
                    r_ptr    <= r_shift[IDX_W-1:0];
                    r_ack    <= 1'b1;
                    r_sda_oe <= 1'b1;
                  end else begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                  end
                end
                default: begin
                  // Injected fault: store the inverted parity so the next read flags it.
                  r_regs[r_ptr] <= r_shift;
                  r_par[r_ptr]  <= even_par(r_shift) ^ (r_inj_pend | par_inject);
                  r_inj_pend    <= 1'b0;
                  r_wr_pulse    <= 1'b1;
                  r_wr_idx      <= r_ptr;
                  r_wr_data     <= r_shift;
                  r_ptr         <= next_ptr(r_ptr);
                  r_ack         <= 1'b1;
                  r_sda_oe      <= 1'b1;
                end
              endcase
            end else if (w_scl_fall && r_ack) begin
              r_ack     <= 1'b0;
              r_bit_cnt <= 4'd0;
              r_sda_oe  <= 1'b0;
              if (r_state == ST_ADDR) begin
                r_state <= r_rw ? ST_RD : ST_PTR;
              end else begin
                r_state <= ST_WR;
              end
            end
          end
          ST_RD: begin
            if (w_scl_fall && !r_ack) begin
              if (r_bit_cnt < 4'd8) begin
                r_sda_oe  <= ~r_shift[7];
                r_shift   <= {r_shift[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end else begin
                r_sda_oe <= 1'b0;
                r_ack    <= 1'b1;
                r_mack   <= 1'b0;
              end
            end else if (w_scl_rise && r_ack) begin
              r_mack <= ~w_sda;
            end else if (w_scl_fall && r_ack && !r_mack) begin
              r_state <= ST_WAIT;
              r_ack   <= 1'b0;
            end
          end
          default: begin
            r_ack <= 1'b0;
          end
        endcase
        if (w_do_load) begin
          r_state   <= ST_RD;
          r_shift   <= {w_rd_byte[6:0], 1'b0};
          r_sda_oe  <= ~w_rd_byte[7];
          r_bit_cnt <= 4'd1;
          r_ack     <= 1'b0;
          r_ptr     <= next_ptr(r_ptr);
          r_par_err <= w_rd_par_bad;
        end
      end
    end
  end

  // Local read port; indices beyond the file read as zero.
  always_comb begin
    app_rdata = 8'd0;
    if (32'(app_idx) < 32'(NUM_REGS)) begin
      app_rdata = r_regs[app_idx];
    end else begin
      app_rdata = 8'd0;
    end
  end

  assign sda_oe       = r_sda_oe;
  assign busy         = r_busy;
  assign bus_wr_pulse = r_wr_pulse;
  assign bus_wr_idx   = r_wr_idx;
  assign bus_wr_data  = r_wr_data;
  assign parity_err   = (PARITY_EN != 0) ? r_par_err : 1'b0;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: a bit-banged I2C master on a wired-AND SDA
// with hand-computed expected bytes, ACKs and write strobes.
module tb_i2c_target_regfile;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       sda_m;
  logic       par_inject;
  logic [6:0] slave_addr;
  logic [3:0] app_idx;
  logic       sda_oe;
  logic [7:0] app_rdata;
  logic       bus_wr_pulse;
  logic [3:0] bus_wr_idx;
  logic [7:0] bus_wr_data;
  logic       busy;
  logic       parity_err;
  logic       sda_bus;

  int n_checks = 0;
  int n_errors = 0;
  int n_perr   = 0;
  int n_oe_viol = 0;
  logic oe_seen = 1'b0;
  logic prev_oe = 1'b0;
  logic [3:0] wr_idx_q [$];
  logic [7:0] wr_data_q [$];
  logic       ack;
  logic [7:0] rd;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regfile #(.NUM_REGS(16), .SYNC_STAGES(2), .PARITY_EN(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .slave_addr   (slave_addr),
    .scl_i        (scl),
    .sda_i        (sda_bus),
    .sda_oe       (sda_oe),
    .app_idx      (app_idx),
    .app_rdata    (app_rdata),
    .bus_wr_pulse (bus_wr_pulse),
    .bus_wr_idx   (bus_wr_idx),
    .bus_wr_data  (bus_wr_data),
    .busy         (busy),
    .par_inject   (par_inject),
    .parity_err   (parity_err)
  );

  // Bus-side monitor: collects write strobes, parity strobes and SDA drive behaviour.
  always @(negedge clk) begin
    if (bus_wr_pulse) begin
      wr_idx_q.push_back(bus_wr_idx);
      wr_data_q.push_back(bus_wr_data);
    end
    if (parity_err) n_perr++;
    if (sda_oe) oe_seen = 1'b1;
    if (rst_n && sda_oe && !prev_oe && scl) n_oe_viol++;
    prev_oe = sda_oe;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input logic [3:0] ei, input logic [7:0] ed);
    logic [11:0] got;
    got = 12'hFFF;
    if (wr_idx_q.size() > 0) got = {wr_idx_q.pop_front(), wr_data_q.pop_front()};
    check_val(tag, 32'(got), 32'({ei, ed}));
  endtask

  task automatic q_wait();
    repeat (8) @(negedge clk);
  endtask

  task automatic i2c_start();
    q_wait(); sda_m = 1'b1;
    q_wait(); scl = 1'b1;
    q_wait(); sda_m = 1'b0;
    q_wait(); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    q_wait(); sda_m = 1'b0;
    q_wait(); scl = 1'b1;
    q_wait(); sda_m = 1'b1;
    q_wait();
  endtask

  task automatic send_bit(input logic b);
    q_wait(); sda_m = b;
    q_wait(); scl = 1'b1;
    q_wait(); q_wait(); scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    q_wait(); sda_m = 1'b1;
    q_wait(); scl = 1'b1;
    q_wait(); b = sda_bus;
    q_wait(); scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic a);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(b);
    a = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    logic b;
    d = 8'd0;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    send_bit(~mack);
  endtask

  initial begin
    logic b;
    rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1; par_inject = 1'b0;
    slave_addr = 7'h50; app_idx = 4'd0;
    repeat (3) @(negedge clk);
    check_val("rst_sda_oe", 32'(sda_oe), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_wr_pulse", 32'(bus_wr_pulse), 32'd0);
    check_val("rst_parity_err", 32'(parity_err), 32'd0);
    check_val("rst_app_rdata", 32'(app_rdata), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Test 1: plain write of two bytes from pointer 3
    i2c_start();
    write_byte(8'hA0, ack); check_val("t1_addr_ack", 32'(ack), 32'd1);
    check_val("t1_busy_high", 32'(busy), 32'd1);
    write_byte(8'h03, ack); check_val("t1_ptr_ack", 32'(ack), 32'd1);
    write_byte(8'hA5, ack); check_val("t1_d0_ack", 32'(ack), 32'd1);
    write_byte(8'h5A, ack); check_val("t1_d1_ack", 32'(ack), 32'd1);
    i2c_stop();
    check_val("t1_busy_low", 32'(busy), 32'd0);
    check_wr("t1_wr0", 4'd3, 8'hA5);
    check_wr("t1_wr1", 4'd4, 8'h5A);
    app_idx = 4'd4; @(negedge clk);
    check_val("t1_app_rdata4", 32'(app_rdata), 32'h5A);

    // Test 2: write with pointer wrap, then pointer-set + repeated START + read with wrap
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h0F, ack);
    write_byte(8'h77, ack);
    write_byte(8'h81, ack); check_val("t2_wrap_ack", 32'(ack), 32'd1);
    i2c_stop();
    check_wr("t2_wr15", 4'd15, 8'h77);
    check_wr("t2_wr0", 4'd0, 8'h81);
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h0F, ack); check_val("t2_ptr_ack", 32'(ack), 32'd1);
    i2c_start();
    write_byte(8'hA1, ack); check_val("t2_rd_addr_ack", 32'(ack), 32'd1);
    read_byte(rd, 1'b1); check_val("t2_rd_reg15", 32'(rd), 32'h77);
    read_byte(rd, 1'b0); check_val("t2_rd_reg0", 32'(rd), 32'h81);
    q_wait();
    check_val("t2_oe_after_nack", 32'(sda_oe), 32'd0);
    i2c_stop();
    check_val("t2_no_parity_err", 32'(n_perr), 32'd0);

    // Test 3: foreign address is ignored
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'hA2, ack); check_val("t3_no_ack", 32'(ack), 32'd0);
    check_val("t3_busy", 32'(busy), 32'd0);
    write_byte(8'h01, ack);
    i2c_stop();
    check_val("t3_oe_never", 32'(oe_seen), 32'd0);
    check_val("t3_no_wr", 32'(wr_idx_q.size()), 32'd0);

    // Test 4: out-of-range pointer is NACKed and later data ignored
    i2c_start();
    write_byte(8'hA0, ack); check_val("t4_addr_ack", 32'(ack), 32'd1);
    write_byte(8'h20, ack); check_val("t4_ptr_nack", 32'(ack), 32'd0);
    write_byte(8'h99, ack); check_val("t4_data_nack", 32'(ack), 32'd0);
    i2c_stop();
    check_val("t4_no_wr", 32'(wr_idx_q.size()), 32'd0);
    app_idx = 4'd0; @(negedge clk);
    check_val("t4_reg0_kept", 32'(app_rdata), 32'h81);

    // Test 5: injected parity fault is reported on read, data untouched
    par_inject = 1'b1; @(negedge clk); par_inject = 1'b0;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h02, ack);
    write_byte(8'h3C, ack);
    i2c_stop();
    check_wr("t5_wr2", 4'd2, 8'h3C);
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h02, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    read_byte(rd, 1'b0); check_val("t5_rd_byte", 32'(rd), 32'h3C);
    i2c_stop();
    check_val("t5_parity_pulses", 32'(n_perr), 32'd1);

    // Test 6: reset during the 4th bit of a read byte (reg3 = A5, 4th bit is 0)
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h03, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    for (int i = 0; i < 3; i++) read_bit(b);
    q_wait(); sda_m = 1'b1;
    q_wait(); scl = 1'b1;
    q_wait();
    check_val("t6_oe_before_rst", 32'(sda_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("t6_oe_in_rst", 32'(sda_oe), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    app_idx = 4'd3;
    repeat (2) @(negedge clk);
    check_val("t6_busy_rst", 32'(busy), 32'd0);
    check_val("t6_reg3_cleared", 32'(app_rdata), 32'd0);
    i2c_start();
    write_byte(8'hA0, ack); check_val("t6_addr_ack", 32'(ack), 32'd1);
    write_byte(8'h00, ack); check_val("t6_ptr_ack", 32'(ack), 32'd1);
    i2c_stop();

    check_val("oe_rise_while_scl_high", 32'(n_oe_viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
